inning_ctrl: RTL

INNING_CTRL -- requirements
Module: inning_ctrl

---
 rtl/baseball_pkg.sv | 33 +++
 rtl/base_advance.sv | 20 ++
 rtl/inning_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/baseball_pkg.sv
// Shared types and constants for the inning controller: FSM states, hitout bit
// positions, default inning count and small arithmetic helpers.
package baseball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPIN   = 3'd1,
        ST_JUDGE  = 3'd2,
        ST_CHANGE = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    // hitout = {hit1, hit2, hit3, hit4, out}
    localparam int unsigned HIT1 = 4;
    localparam int unsigned HIT2 = 3;
    localparam int unsigned HIT3 = 2;
    localparam int unsigned HIT4 = 1;
    localparam int unsigned OUT  = 0;

    localparam int unsigned DEF_N_INNINGS = 3;
    localparam logic [3:0]  MAX_COUNT     = 4'd15;

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [2:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {2'b00, b};
        return sum[4] ? MAX_COUNT : sum[3:0];
    endfunction

endpackage

// File: rtl/base_advance.sv
// Combinational runner advance: every runner and the batter move up by the
// number of bases hit; anyone carried past third base scores.
module base_advance (
    input  logic [2:0] bases_i,
    input  logic [2:0] hits_i,
    output logic [2:0] bases_o,
    output logic [2:0] runs_o
);

    logic [6:0] moved_s;

    // Bit k of moved_s is base k+1 after the hit; bits [6:3] are home plate and beyond.
    always_comb begin
        moved_s = ({4'b0000, bases_i} << hits_i) | (7'b0000001 << (hits_i - 3'd1));
        bases_o = moved_s[2:0];
        runs_o  = {2'b00, moved_s[3]} + {2'b00, moved_s[4]}
                + {2'b00, moved_s[5]} + {2'b00, moved_s[6]};
    end

endmodule

// File: rtl/inning_ctrl.sv
// Roulette baseball inning controller: pitch/swing sequencing, base running,
// outs, half-inning changes, scoring and end-of-game rules.
// Optional macro EXTRA_INNINGS_EN: tied games after regulation go to extra innings.
module inning_ctrl
    import baseball_pkg::*;
#(
    parameter int unsigned N_INNINGS = DEF_N_INNINGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pitch,
    input  logic       swing,
    input  logic [4:0] hitout,
    output logic       active,
    output logic [2:0] bases,
    output logic [1:0] outs,
    output logic [3:0] inning,
    output logic       half,
    output logic [3:0] score_away,
    output logic [3:0] score_home,
    output logic       result_valid,
    output logic       game_over,
    output logic       err
);

    localparam logic [3:0] N_LAST = N_INNINGS[3:0];

    state_e     state_q, state_d;
    logic [2:0] bases_q, bases_d;
    logic [1:0] outs_q, outs_d;
    logic [3:0] inning_q, inning_d;
    logic       half_q, half_d;
    logic [3:0] away_q, away_d;
    logic [3:0] home_q, home_d;
    logic       rv_q, rv_d;
    logic       active_q, active_d;
    logic       over_q, over_d;
    logic       err_q, err_d;

    logic       onehot_s;
    logic       is_hit_s;
    logic       late_s;
    logic [2:0] hit_cnt_s;
    logic [2:0] adv_bases_s;
    logic [2:0] adv_runs_s;
    logic [3:0] home_sum_s;
    logic [3:0] away_sum_s;

    base_advance u_base_advance (
        .bases_i (bases_q),
        .hits_i  (hit_cnt_s),
        .bases_o (adv_bases_s),
        .runs_o  (adv_runs_s)
    );

    // Decode the roulette result into a hit count and validity flags.
    always_comb begin
        onehot_s = is_onehot5(hitout);
        is_hit_s = onehot_s && !hitout[OUT];
        if (hitout[HIT1]) begin
            hit_cnt_s = 3'd1;
        end else if (hitout[HIT2]) begin
            hit_cnt_s = 3'd2;
        end else if (hitout[HIT3]) begin
            hit_cnt_s = 3'd3;
        end else if (hitout[HIT4]) begin
            hit_cnt_s = 3'd4;
        end else begin
            hit_cnt_s = 3'd0;
        end
        late_s     = (inning_q >= N_LAST);
        home_sum_s = sat_add4(home_q, adv_runs_s);
        away_sum_s = sat_add4(away_q, adv_runs_s);
    end

    // Next-state and next-output computation for the game FSM.
    always_comb begin
        state_d  = state_q;
        bases_d  = bases_q;
        outs_d   = outs_q;
        inning_d = inning_q;
        half_d   = half_q;
        away_d   = away_q;
        home_d   = home_q;
        err_d    = err_q;
        rv_d     = 1'b0;
        if (start) begin
            state_d  = ST_IDLE;
            bases_d  = 3'd0;
            outs_d   = 2'd0;
            inning_d = 4'd1;
            half_d   = 1'b0;
            away_d   = 4'd0;
            home_d   = 4'd0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pitch) begin
                        state_d = ST_SPIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SPIN: begin
                    if (swing) begin
                        state_d = ST_JUDGE;
                    end else begin
                        state_d = ST_SPIN;
                    end
                end
                ST_JUDGE: begin
                    rv_d = 1'b1;
                    if (is_hit_s) begin
                        bases_d = adv_bases_s;
                        if (half_q) begin
                            home_d = home_sum_s;
                        end else begin
                            away_d = away_sum_s;
                        end
                        // Walk-off: the home side takes the lead in a deciding inning.
                        if (half_q && late_s && (home_sum_s > away_q)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        err_d = err_q | ~onehot_s;
                        if (outs_q == 2'd2) begin
                            state_d = ST_CHANGE;
                        end else begin
                            outs_d  = outs_q + 2'd1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_CHANGE: begin
                    bases_d = 3'd0;
                    outs_d  = 2'd0;
                    if (!half_q) begin
                        if (late_s && (home_q > away_q)) begin
                            state_d = ST_OVER;
                        end else begin
                            half_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (late_s && (home_q != away_q)) begin
                        state_d = ST_OVER;
                    end else if (late_s) begin
`ifdef EXTRA_INNINGS_EN
                        if (inning_q == MAX_COUNT) begin
                            state_d = ST_OVER;
                        end else begin
                            inning_d = inning_q + 4'd1;
                            half_d   = 1'b0;
                            state_d  = ST_IDLE;
                        end
`else
                        state_d = ST_OVER;
`endif
                    end else begin
                        inning_d = (inning_q == MAX_COUNT) ? MAX_COUNT : inning_q + 4'd1;
                        half_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_OVER;
                end
            endcase
        end
        active_d = (state_d == ST_SPIN);
        over_d   = (state_d == ST_OVER);
    end

    // State and registered outputs; reset parks the game in OVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_OVER;
            bases_q  <= 3'd0;
            outs_q   <= 2'd0;
            inning_q <= 4'd1;
            half_q   <= 1'b0;
            away_q   <= 4'd0;
            home_q   <= 4'd0;
            rv_q     <= 1'b0;
            active_q <= 1'b0;
            over_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bases_q  <= bases_d;
            outs_q   <= outs_d;
            inning_q <= inning_d;
            half_q   <= half_d;
            away_q   <= away_d;
            home_q   <= home_d;
            rv_q     <= rv_d;
            active_q <= active_d;
            over_q   <= over_d;
            err_q    <= err_d;
        end
    end

    assign active       = active_q;
    assign bases        = bases_q;
    assign outs         = outs_q;
    assign inning       = inning_q;
    assign half         = half_q;
    assign score_away   = away_q;
    assign score_home   = home_q;
    assign result_valid = rv_q;
    assign game_over    = over_q;
    assign err          = err_q;

endmodule
